sram_brick_bank: RTL and testbench
==================================

Name: sram_brick_bank

Overview:
- Parametrised successor to the single LIM SRAM brick: NUM_BRICKS bricks stacked on one global read bitline bus.
- One-hot wordline addressing; per-brick read and write enables; masked writes.
- Adds a registered read-valid output, a collision/error detector and a self-clearing init FSM.
- Drives a driven-zero global bus instead of high-Z, so it is synthesisable on FPGA.
- Sits between the LIM controller and the SpMV merge datapath as the local vector/row store.

Parameters:
- BL_WIDTH, `LIM_BRICK_WORD_SIZE: bits per word.
- WL_WIDTH, `LIM_BRICK_WORD_NUM: words (wordlines) per brick.
- ADDR_WIDTH, `BITS_ADDR_LIM_BRICK: log2(WL_WIDTH).
- NUM_BRICKS, 4: bricks on the shared bus.
- MASK_GRAN, 8: bits per write-mask lane; BL_WIDTH must be a multiple of MASK_GRAN.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- CLR_REQ  in  1  start a full zero-clear; ignored while BUSY.
- BUSY  out  1  clear FSM active; reads and writes are dropped.
- BLK_RE  in  NUM_BRICKS  per-brick read enable; must be one-hot or zero.
- DRWL  in  WL_WIDTH  read wordlines, one-hot.
- BLK_WE  in  NUM_BRICKS  per-brick write enable; any number of bits may be set (broadcast write).
- DWWL  in  WL_WIDTH  write wordlines, one-hot.
- WBL  in  BL_WIDTH  write data.
- WMASK  in  BL_WIDTH/MASK_GRAN  lane write enables; 1 = write the lane.
- ARBL  out  BL_WIDTH  global read data.
- ARBL_VLD  out  1  ARBL holds a valid read result.
- COLL_ERR  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (RST_N low):
  - ARBL=0, ARBL_VLD=0, COLL_ERR=0, BUSY=1.
  - FSM forced to CLEAR with row counter 0.
  - Memory contents are not reset asynchronously; the CLEAR pass zeroes them.
- FSM states:
  - CLEAR: every cycle, writes 0 to row cnt of all bricks; cnt increments. Exits to IDLE after the cycle with cnt==WL_WIDTH-1, so the pass takes exactly WL_WIDTH cycles; BUSY deasserts the cycle after the last row is written.
  - IDLE: BUSY=0. CLR_REQ=1 moves to CLEAR next cycle with cnt=0.
  - Reset mid-clear restarts the pass at row 0.
- Read, legal request (BLK_RE one-hot, DRWL one-hot, BUSY=0):
  - ARBL = word of the selected brick at the encoded row, registered at posedge N.
  - ARBL_VLD=1 in cycle N+1; latency 1.
- No read: BLK_RE=0, or request illegal, or BUSY=1 -> ARBL=0 and ARBL_VLD=0 next cycle.
- Write, legal request (BLK_WE!=0, DWWL one-hot, BUSY=0): every enabled brick updates only the lanes with WMASK=1 at posedge. WMASK=0 -> no change, legal.
- Illegal requests -> operation dropped, COLL_ERR=1 next cycle:
  - BLK_RE with more than one bit set.
  - BLK_RE!=0 while DRWL is not one-hot.
  - BLK_WE!=0 while DWWL is not one-hot.
  - If both the read and the write are illegal, a single pulse is raised.
- Any request made while BUSY is silently dropped; COLL_ERR stays 0.
- Same-cycle read and write to the same brick and row: read returns the pre-write data (read-first).
- Row encoding: one-hot -> binary via a priority-free OR-tree encoder. The one-hot check is done separately: popcount==1.

Optional Feature:
- Macro: LIM_BRICK_RDW_BYPASS_EN.
- Defined: a same-cycle read and write to the same brick and row returns the merged word (new lanes where WMASK=1, old lanes elsewhere). Latency is unchanged.
- Undefined: read-first behaviour as above.

Decomposition:
- Package lim_brick_pkg:
  - clr_state_t enum {IDLE, CLEAR}.
  - Function onehot_chk (popcount==1).
  - Function onehot2bin.
  - Localparam MASK_W = BL_WIDTH/MASK_GRAN.
- Sub-module sram_brick_core: a single storage array with one-hot-to-binary encoders, masked write and registered read.
  - Instantiated NUM_BRICKS times via generate.
  - Outputs are OR-reduced onto ARBL, which is valid because reads are one-hot.
  - Clear FSM, legality checks and bypass logic live in the top.

Test Plan (BL_WIDTH=32, WL_WIDTH=16, NUM_BRICKS=4, MASK_GRAN=8):
- Release RST_N -> BUSY high exactly 16 cycles. Then read brick2, row 5 -> ARBL=0x00000000, ARBL_VLD=1 one cycle later.
- Write BLK_WE=4'b0010, DWWL=1<<3, WBL=0xDEADBEEF, WMASK=4'b0101; then read brick1, row 3 -> ARBL=0x00AD00EF. Brick0, row 3 reads 0.
- Broadcast: BLK_WE=4'b1111, row 7, WBL=0x12345678, WMASK=4'hF -> reads of each brick at row 7 return 0x12345678.
- Illegal requests:
  - BLK_RE=4'b0011 -> COLL_ERR pulses once, ARBL_VLD=0.
  - DWWL=16'h0003 with BLK_WE=1 -> COLL_ERR pulses once, memory unchanged.
- Same-cycle write 0xCAFEF00D and read of the same row, which holds 0x11111111:
  - Without the macro -> 0x11111111.
  - With LIM_BRICK_RDW_BYPASS_EN -> 0xCAFEF00D.
- Clear interactions:
  - CLR_REQ with rows written, plus a write issued during BUSY -> all rows read 0 afterwards.
  - RST_N pulsed at clear row 9 -> a new 16-cycle BUSY window.

Source files
------------

// File: rtl/lim_brick_pkg.sv
// Shared types and helpers for the LIM SRAM brick bank: clear-FSM state
// encoding, one-hot legality check and one-hot to binary encoding.
package lim_brick_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   // Default geometry, used when the bank is built without overrides.
   localparam int DEF_BL_WIDTH   = 32;
   localparam int DEF_WL_WIDTH   = 16;
   localparam int DEF_MASK_GRAN  = 8;
   localparam int MASK_W         = DEF_BL_WIDTH / DEF_MASK_GRAN;

   // Helpers take a fixed-width vector; callers zero-extend into it.
   localparam int MAX_W = 64;
   localparam int ENC_W = 6;

   // True when exactly one bit is set.
   function automatic logic onehot_chk(input logic [MAX_W-1:0] v);
      return ($countones(v) == 1);
   endfunction

   // OR-tree encoder: every set bit ORs its own index into the result, so
   // there is no priority chain. Only meaningful for one-hot inputs.
   function automatic logic [ENC_W-1:0] onehot2bin(input logic [MAX_W-1:0] v);
      logic [ENC_W-1:0] b;
      b = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (v[i]) b = b | ENC_W'(i);
      end
      return b;
   endfunction

endpackage

// File: rtl/sram_brick_bank_core.sv
// One SRAM brick: a WL_WIDTH x BL_WIDTH array with one-hot wordline
// encoders, lane-masked write and a registered read that returns zero when
// the brick is not being read, so several bricks can be OR-ed onto one bus.
module sram_brick_bank_core
   import lim_brick_pkg::*;
#(
   parameter int BL_WIDTH   = DEF_BL_WIDTH,
   parameter int WL_WIDTH   = DEF_WL_WIDTH,
   parameter int ADDR_WIDTH = $clog2(DEF_WL_WIDTH),
   parameter int MASK_GRAN  = DEF_MASK_GRAN
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          re,
   input  logic [WL_WIDTH-1:0]           rwl,
   input  logic                          we,
   input  logic [WL_WIDTH-1:0]           wwl,
   input  logic [BL_WIDTH-1:0]           wbl,
   input  logic [BL_WIDTH/MASK_GRAN-1:0] wmask,
   output logic [BL_WIDTH-1:0]           rdata
);

   localparam int LANES = BL_WIDTH / MASK_GRAN;

   logic [BL_WIDTH-1:0]   mem [WL_WIDTH];
   logic [ADDR_WIDTH-1:0] raddr;
   logic [ADDR_WIDTH-1:0] waddr;

   assign raddr = ADDR_WIDTH'(onehot2bin(MAX_W'(rwl)));
   assign waddr = ADDR_WIDTH'(onehot2bin(MAX_W'(wwl)));

   // Storage: lane-masked write, contents are never reset (cleared by the FSM).
   always_ff @(posedge CLK) begin
      if (we) begin
         for (int l = 0; l < LANES; l++) begin
            if (wmask[l]) mem[waddr][l*MASK_GRAN +: MASK_GRAN] <= wbl[l*MASK_GRAN +: MASK_GRAN];
         end
      end
   end

   // Registered read; the old word is captured, giving read-first ordering.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) rdata <= '0;
      else        rdata <= re ? mem[raddr] : '0;
   end

endmodule

// File: rtl/sram_brick_bank.sv
// NUM_BRICKS SRAM bricks on one driven-zero global read bus, with a
// self-clearing init FSM, request legality checking and a read-valid flag.
// Optional macro LIM_BRICK_RDW_BYPASS_EN: a same-cycle read and write of the
// same brick and row returns the merged (post-write) word instead of the old.
// Requests are single-cycle strobes with no backpressure: a request is taken
// in the cycle it is presented unless BUSY is high, in which case it is lost.
module sram_brick_bank
   import lim_brick_pkg::*;
#(
   parameter int BL_WIDTH   = DEF_BL_WIDTH,
   parameter int WL_WIDTH   = DEF_WL_WIDTH,
   parameter int ADDR_WIDTH = $clog2(DEF_WL_WIDTH),
   parameter int NUM_BRICKS = 4,
   parameter int MASK_GRAN  = DEF_MASK_GRAN
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          CLR_REQ,
   output logic                          BUSY,
   input  logic [NUM_BRICKS-1:0]         BLK_RE,
   input  logic [WL_WIDTH-1:0]           DRWL,
   input  logic [NUM_BRICKS-1:0]         BLK_WE,
   input  logic [WL_WIDTH-1:0]           DWWL,
   input  logic [BL_WIDTH-1:0]           WBL,
   input  logic [BL_WIDTH/MASK_GRAN-1:0] WMASK,
   output logic [BL_WIDTH-1:0]           ARBL,
   output logic                          ARBL_VLD,
   output logic                          COLL_ERR,
   output clr_state_t                    DBG_CLR_STATE
);

   localparam int LANES = BL_WIDTH / MASK_GRAN;

   clr_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   logic rd_req, rd_ok, rd_go, wr_req, wr_ok, wr_go;

   logic [NUM_BRICKS-1:0]  core_re, core_we;
   logic [WL_WIDTH-1:0]    core_wwl;
   logic [BL_WIDTH-1:0]    core_wbl;
   logic [LANES-1:0]       core_wmask;
   logic [BL_WIDTH-1:0]    brick_rd [NUM_BRICKS];
   logic [BL_WIDTH-1:0]    bus_or;

   assign BUSY          = (state_q == CLEAR);
   assign DBG_CLR_STATE = state_q;

   assign rd_req = |BLK_RE;
   assign rd_ok  = onehot_chk(MAX_W'(BLK_RE)) && onehot_chk(MAX_W'(DRWL));
   assign rd_go  = !BUSY && rd_req && rd_ok;
   assign wr_req = |BLK_WE;
   assign wr_ok  = onehot_chk(MAX_W'(DWWL));
   assign wr_go  = !BUSY && wr_req && wr_ok;

   // Clear FSM state and row counter.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Clear FSM next state: sweep every row once, then idle until CLR_REQ.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            if (cnt_q == ADDR_WIDTH'(WL_WIDTH-1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         IDLE: begin
            if (CLR_REQ) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   // Brick port steering: the clear pass owns the write port while BUSY.
   always_comb begin
      core_re    = rd_go ? BLK_RE : '0;
      core_we    = wr_go ? BLK_WE : '0;
      core_wwl   = DWWL;
      core_wbl   = WBL;
      core_wmask = WMASK;
      if (BUSY) begin
         core_we    = '1;
         core_wwl   = WL_WIDTH'(1) << cnt_q;
         core_wbl   = '0;
         core_wmask = '1;
      end
   end

   for (genvar g = 0; g < NUM_BRICKS; g++) begin : g_brick
      sram_brick_bank_core #(
         .BL_WIDTH   (BL_WIDTH),
         .WL_WIDTH   (WL_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .MASK_GRAN  (MASK_GRAN)
      ) u_core (
         .CLK   (CLK),
         .RST_N (RST_N),
         .re    (core_re[g]),
         .rwl   (DRWL),
         .we    (core_we[g]),
         .wwl   (core_wwl),
         .wbl   (core_wbl),
         .wmask (core_wmask),
         .rdata (brick_rd[g])
      );
   end

   // Global bus: unselected bricks drive zero, and reads are one-hot.
   always_comb begin
      bus_or = '0;
      for (int b = 0; b < NUM_BRICKS; b++) bus_or = bus_or | brick_rd[b];
   end

   // Read-valid and collision pulse, both one cycle after the request.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ARBL_VLD <= 1'b0;
         COLL_ERR <= 1'b0;
      end else begin
         ARBL_VLD <= rd_go;
         COLL_ERR <= !BUSY && ((rd_req && !rd_ok) || (wr_req && !wr_ok));
      end
   end

`ifdef LIM_BRICK_RDW_BYPASS_EN
   logic                byp_hit;
   logic [BL_WIDTH-1:0] byp_mask_d, byp_mask_q, byp_wbl_q;

   assign byp_hit = rd_go && wr_go && (|(BLK_RE & BLK_WE)) && (DRWL == DWWL);

   // Expand the lane mask to bits, qualified by a same brick/row hit.
   always_comb begin
      byp_mask_d = '0;
      for (int l = 0; l < LANES; l++) begin
         byp_mask_d[l*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{byp_hit & WMASK[l]}};
      end
   end

   // Capture the new data alongside the old word read by the brick.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         byp_mask_q <= '0;
         byp_wbl_q  <= '0;
      end else begin
         byp_mask_q <= byp_mask_d;
         byp_wbl_q  <= WBL;
      end
   end

   assign ARBL = (bus_or & ~byp_mask_q) | (byp_wbl_q & byp_mask_q);
`else
   assign ARBL = bus_or;
`endif

endmodule

// File: tb/tb_sram_brick_bank.sv
// Randomised and directed bench for sram_brick_bank against a word-level
// model of the bank (memory array plus a busy-cycle countdown).
module tb_sram_brick_bank;
   import lim_brick_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        CLR_REQ = 1'b0;
   logic        BUSY;
   logic [3:0]  BLK_RE = '0;
   logic [15:0] DRWL = '0;
   logic [3:0]  BLK_WE = '0;
   logic [15:0] DWWL = '0;
   logic [31:0] WBL = '0;
   logic [3:0]  WMASK = '0;
   logic [31:0] ARBL;
   logic        ARBL_VLD;
   logic        COLL_ERR;
   clr_state_t  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m [4][16];
   int          busy_left = 0;
   logic [31:0] exp_q[$];

   sram_brick_bank #(
      .BL_WIDTH(32), .WL_WIDTH(16), .ADDR_WIDTH(4), .NUM_BRICKS(4), .MASK_GRAN(8)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .CLR_REQ(CLR_REQ), .BUSY(BUSY),
      .BLK_RE(BLK_RE), .DRWL(DRWL), .BLK_WE(BLK_WE), .DWWL(DWWL),
      .WBL(WBL), .WMASK(WMASK), .ARBL(ARBL), .ARBL_VLD(ARBL_VLD),
      .COLL_ERR(COLL_ERR), .DBG_CLR_STATE(dbg_state)
   );

   // Clock.
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_zero();
      for (int k = 0; k < 4; k++)
         for (int r = 0; r < 16; r++) m[k][r] = '0;
   endtask

   // One clock of stimulus; the model predicts outputs seen after the edge.
   task automatic cycle(input string tag, input logic [3:0] re, input logic [15:0] drwl,
                        input logic [3:0] we, input logic [15:0] dwwl,
                        input logic [31:0] wbl, input logic [3:0] wmask, input logic clr);
      logic        pre_busy, rd_ok, wr_ok, exp_vld, exp_coll;
      int          b, r, w;
      logic [31:0] exp_d;
      BLK_RE = re; DRWL = drwl; BLK_WE = we; DWWL = dwwl;
      WBL = wbl; WMASK = wmask; CLR_REQ = clr;
      pre_busy = (busy_left > 0);
      rd_ok    = ($countones(re) == 1) && ($countones(drwl) == 1);
      wr_ok    = ($countones(dwwl) == 1);
      exp_vld  = !pre_busy && rd_ok;
      exp_coll = !pre_busy && (((re != 0) && !rd_ok) || ((we != 0) && !wr_ok));
      b = 0; r = 0; w = 0;
      for (int i = 0; i < 4; i++) if (re[i]) b = i;
      for (int i = 0; i < 16; i++) begin
         if (drwl[i]) r = i;
         if (dwwl[i]) w = i;
      end
      exp_d = exp_vld ? m[b][r] : 32'h0;
      if (!pre_busy && (we != 0) && wr_ok) begin
`ifdef LIM_BRICK_RDW_BYPASS_EN
         if (exp_vld && we[b] && (w == r))
            for (int l = 0; l < 4; l++) if (wmask[l]) exp_d[l*8 +: 8] = wbl[l*8 +: 8];
`endif
         for (int k = 0; k < 4; k++)
            for (int l = 0; l < 4; l++)
               if (we[k] && wmask[l]) m[k][w][l*8 +: 8] = wbl[l*8 +: 8];
      end
      if (pre_busy) busy_left--;
      else if (clr) begin
         busy_left = 16;
         model_zero();
      end
      exp_q.push_back(exp_d);
      @(posedge CLK); #1;
      check({tag, ".arbl"}, ARBL, exp_q.pop_front());
      check({tag, ".vld"}, 32'(ARBL_VLD), 32'(exp_vld));
      check({tag, ".coll"}, 32'(COLL_ERR), 32'(exp_coll));
      check({tag, ".busy"}, 32'(BUSY), 32'(busy_left > 0));
   endtask

   task automatic idle(input string tag);
      cycle(tag, 4'h0, 16'h0, 4'h0, 16'h0, 32'h0, 4'h0, 1'b0);
   endtask

   task automatic rd(input string tag, input int b, input int r);
      cycle(tag, 4'(1 << b), 16'(1 << r), 4'h0, 16'h0, 32'h0, 4'h0, 1'b0);
   endtask

   task automatic wr(input string tag, input logic [3:0] we, input int r,
                     input logic [31:0] d, input logic [3:0] mask);
      cycle(tag, 4'h0, 16'h0, we, 16'(1 << r), d, mask, 1'b0);
   endtask

   // Apply reset, check reset values, release, and measure the BUSY window.
   task automatic reset_and_clear(input string tag);
      int n;
      BLK_RE = '0; BLK_WE = '0; DRWL = '0; DWWL = '0; CLR_REQ = 1'b0;
      RST_N = 1'b0;
      #1;
      check({tag, ".rst_arbl"}, ARBL, 32'h0);
      check({tag, ".rst_vld"}, 32'(ARBL_VLD), 32'h0);
      check({tag, ".rst_coll"}, 32'(COLL_ERR), 32'h0);
      check({tag, ".rst_busy"}, 32'(BUSY), 32'h1);
      check({tag, ".rst_state"}, 32'(dbg_state), 32'(CLEAR));
      @(posedge CLK); #1;
      RST_N = 1'b1;
      n = 0;
      while (BUSY && n < 100) begin
         n++;
         @(posedge CLK); #1;
      end
      check({tag, ".busy_window"}, 32'(n), 32'd16);
      busy_left = 0;
      model_zero();
   endtask

   initial begin
      logic [3:0]  re, we, mk;
      logic [15:0] rw, ww;
      repeat (3) @(posedge CLK);
      #1;
      reset_and_clear("por");

      rd("rd_zero", 2, 5);
      check("rd_zero.lit", ARBL, 32'h0000_0000);

      wr("mask_wr", 4'b0010, 3, 32'hDEAD_BEEF, 4'b0101);
      rd("mask_rd1", 1, 3);
      check("mask_rd1.lit", ARBL, 32'h00AD_00EF);
      rd("mask_rd0", 0, 3);

      wr("bcast_wr", 4'b1111, 7, 32'h1234_5678, 4'hF);
      for (int b = 0; b < 4; b++) begin
         rd("bcast_rd", b, 7);
         check("bcast_rd.lit", ARBL, 32'h1234_5678);
      end

      cycle("ill_re", 4'b0011, 16'h0004, 4'h0, 16'h0, 32'h0, 4'h0, 1'b0);
      idle("ill_re_after");
      cycle("ill_wwl", 4'h0, 16'h0, 4'b0001, 16'h0003, 32'hFFFF_FFFF, 4'hF, 1'b0);
      idle("ill_wwl_after");
      rd("ill_wwl_r0", 0, 0);
      rd("ill_wwl_r1", 0, 1);

      wr("rdw_pre", 4'b1000, 9, 32'h1111_1111, 4'hF);
      cycle("rdw", 4'b1000, 16'h0200, 4'b1000, 16'h0200, 32'hCAFE_F00D, 4'hF, 1'b0);
`ifdef LIM_BRICK_RDW_BYPASS_EN
      check("rdw.lit", ARBL, 32'hCAFE_F00D);
`else
      check("rdw.lit", ARBL, 32'h1111_1111);
`endif
      rd("rdw_post", 3, 9);

      cycle("clr_req", 4'h0, 16'h0, 4'h0, 16'h0, 32'h0, 4'h0, 1'b1);
      wr("clr_busy_wr", 4'b0100, 2, 32'hA5A5_A5A5, 4'hF);
      for (int i = 0; i < 40 && busy_left > 0; i++) idle("clr_wait");
      for (int r = 0; r < 16; r++) rd("clr_rd", r % 4, r);
      rd("clr_rd7", 1, 7);
      check("clr_rd7.lit", ARBL, 32'h0);

      wr("mid_pre", 4'b0001, 12, 32'h7777_7777, 4'hF);
      cycle("mid_clr", 4'h0, 16'h0, 4'h0, 16'h0, 32'h0, 4'h0, 1'b1);
      repeat (9) idle("mid_run");
      reset_and_clear("mid_rst");
      rd("mid_rd", 0, 12);

      for (int t = 0; t < 400; t++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: re = 4'(1 << $urandom_range(0, 3));
            6, 7:             re = 4'h0;
            default:          re = 4'($urandom_range(0, 15));
         endcase
         rw = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'(1 << $urandom_range(0, 15));
         we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         ww = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'(1 << $urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) ww = rw;
         mk = 4'($urandom_range(0, 15));
         cycle("rand", re, rw, we, ww, 32'($urandom), mk, ($urandom_range(0, 59) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
